// File: rtl/load_align_unit.sv
// MEM-stage load unit: word-aligned bus master with alignment check,
// byte/halfword/word extraction and a registered, backpressured result.
module load_align_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [7:0]        ld_op,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_addr_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_ok,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic              res_adel,
    output logic [ADDR_W-1:0] res_badvaddr,
    input  logic              flush,
    output logic              stall
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(NBYTES);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(NBYTES - 1);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DRAIN,
        RESP
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        op_q, op_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [31:0]       data_q, data_nxt;
    logic              adel_q, adel_nxt;
    logic [ADDR_W-1:0] bad_q, bad_nxt;

    logic              accept;
    logic              misaligned;
    logic [7:0]        lanes [NBYTES];
    logic [OFF_W-1:0]  off;
    logic [7:0]        b0, b1, b2, b3;
    logic [15:0]       half;
    logic [31:0]       word;
    logic [31:0]       extracted;

    // Unrecognised ops fall through to the word rule.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        case (op)
            EXE_LB_OP, EXE_LBU_OP: return 1'b0;
            EXE_LH_OP, EXE_LHU_OP: return a[0];
            EXE_LW_OP:             return |a;
            default:               return |a;
        endcase
    endfunction

    for (genvar k = 0; k < NBYTES; k++) begin : g_lane
        if (BIG_ENDIAN) begin : g_be
            assign lanes[k] = mem_rdata[DATA_W-1-8*k -: 8];
        end else begin : g_le
            assign lanes[k] = mem_rdata[8*k +: 8];
        end
    end

    assign off = addr_q[OFF_W-1:0];

    always_comb begin
        b0 = lanes[off];
        b1 = lanes[off + OFF_W'(1)];
        b2 = lanes[off + OFF_W'(2)];
        b3 = lanes[off + OFF_W'(3)];
        if (BIG_ENDIAN) begin
            half = {b0, b1};
            word = {b0, b1, b2, b3};
        end else begin
            half = {b1, b0};
            word = {b3, b2, b1, b0};
        end
        case (op_q)
            EXE_LB_OP:  extracted = {{24{b0[7]}}, b0};
            EXE_LBU_OP: extracted = {{24{1'b0}}, b0};
            EXE_LH_OP:  extracted = {{16{half[15]}}, half};
            EXE_LHU_OP: extracted = {{16{1'b0}}, half};
            default:    extracted = word;
        endcase
    end

    assign accept     = ld_valid && (state == IDLE) && !flush;
    assign misaligned = is_misaligned(ld_op, ld_addr[1:0]);

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        adel_nxt  = adel_q;
        bad_nxt   = bad_q;
        ld_ready  = (state == IDLE);
        stall     = (state != IDLE);
        mem_req   = (state == ADDR);
        res_valid = (state == RESP);

        case (state)
            IDLE: begin
                if (accept) begin
                    op_nxt   = ld_op;
                    addr_nxt = ld_addr;
                    if (misaligned) begin
                        state_nxt = RESP;
                        data_nxt  = '0;
                        adel_nxt  = 1'b1;
                        bad_nxt   = ld_addr;
                    end else begin
                        state_nxt = ADDR;
                    end
                end
            end
            ADDR: begin
                // An accepted request must still have its data consumed.
                if (mem_addr_ok) begin
                    state_nxt = flush ? DRAIN : DATA;
                end else if (flush) begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RESP;
                        data_nxt  = extracted;
                        adel_nxt  = 1'b0;
                        bad_nxt   = '0;
                    end
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                if (res_ready || flush) begin
                    state_nxt = IDLE;
                    adel_nxt  = 1'b0;
                    bad_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            adel_q <= 1'b0;
            bad_q  <= '0;
        end else begin
            state  <= state_nxt;
            op_q   <= op_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            adel_q <= adel_nxt;
            bad_q  <= bad_nxt;
        end
    end

    assign mem_addr     = addr_q & ~OFF_MASK;
    assign res_data     = data_q;
    assign res_adel     = adel_q;
    assign res_badvaddr = bad_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: a 32-bit big-endian and a 64-bit little-endian
// instance share one stimulus stream and are checked against a byte-level model.
`timescale 1ns/1ps
module tb_load_align_unit;

    localparam logic [7:0] LB  = 8'hE0;
    localparam logic [7:0] LBU = 8'hE4;
    localparam logic [7:0] LH  = 8'hE1;
    localparam logic [7:0] LHU = 8'hE5;
    localparam logic [7:0] LW  = 8'hE3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_op = 8'h00;
    logic [31:0] ld_addr = 32'h0;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic        res_ready = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rdata32 = 32'h0;
    logic [63:0] rdata64 = 64'h0;

    logic        a_ready, a_req, a_rv, a_adel, a_stall;
    logic [31:0] a_maddr, a_data, a_bad;
    logic        b_ready, b_req, b_rv, b_adel, b_stall;
    logic [31:0] b_maddr, b_data, b_bad;

    load_align_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b1)) u32 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_op(ld_op), .ld_addr(ld_addr),
        .ld_ready(a_ready), .mem_req(a_req), .mem_addr(a_maddr), .mem_addr_ok(mem_addr_ok),
        .mem_rdata(rdata32), .mem_data_ok(mem_data_ok), .res_valid(a_rv), .res_ready(res_ready),
        .res_data(a_data), .res_adel(a_adel), .res_badvaddr(a_bad), .flush(flush), .stall(a_stall)
    );

    load_align_unit #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(1'b0)) u64 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_op(ld_op), .ld_addr(ld_addr),
        .ld_ready(b_ready), .mem_req(b_req), .mem_addr(b_maddr), .mem_addr_ok(mem_addr_ok),
        .mem_rdata(rdata64), .mem_data_ok(mem_data_ok), .res_valid(b_rv), .res_ready(res_ready),
        .res_data(b_data), .res_adel(b_adel), .res_badvaddr(b_bad), .flush(flush), .stall(b_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size, alignment, and value assembled byte by byte.
    function automatic int ref_size(input logic [7:0] op);
        case (op)
            LB, LBU: return 1;
            LH, LHU: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_adel(input logic [7:0] op, input logic [31:0] addr);
        return (int'(addr[1:0]) % ref_size(op)) != 0;
    endfunction

    function automatic logic [31:0] ref_val(input logic [7:0] op, input logic [31:0] addr,
                                            input logic [63:0] rd, input int nb, input bit be);
        int          n;
        int          off;
        int          lane;
        logic [7:0]  b;
        logic [31:0] v;
        n   = ref_size(op);
        off = int'(addr[2:0]) % nb;
        v   = 32'h0;
        if (ref_adel(op, addr)) return 32'h0;
        for (int i = 0; i < n; i++) begin
            lane = off + i;
            b = be ? rd[8*nb-8-8*lane +: 8] : rd[8*lane +: 8];
            if (be) v = {v[23:0], b};
            else    v = v | ({24'h0, b} << (8*i));
        end
        if (op == LB && v[7])  v[31:8]  = '1;
        if (op == LH && v[15]) v[31:16] = '1;
        return v;
    endfunction

    // Issues one load with the given bus wait states; returns once res_valid is seen.
    task automatic run_load(input logic [7:0] op, input logic [31:0] addr, input logic [63:0] rd,
                            input int aw, input int dwt, output int lat, output bit req_seen,
                            output logic [31:0] ma32, output logic [31:0] ma64);
        rdata32  = rd[31:0];
        rdata64  = rd;
        ld_valid = 1'b1;
        ld_op    = op;
        ld_addr  = addr;
        step();
        ld_valid = 1'b0;
        lat      = 1;
        req_seen = 1'b0;
        ma32     = 32'h0;
        ma64     = 32'h0;
        if (a_req) begin
            req_seen = 1'b1;
            ma32     = a_maddr;
            ma64     = b_maddr;
            repeat (aw) begin step(); lat++; end
            mem_addr_ok = 1'b1;
            step();
            mem_addr_ok = 1'b0;
            lat++;
            repeat (dwt) begin step(); lat++; end
            mem_data_ok = 1'b1;
            step();
            mem_data_ok = 1'b0;
            lat++;
        end
        while (!a_rv && lat < 40) begin step(); lat++; end
        chkb("res_valid_arrives", a_rv, 1'b1);
    endtask

    task automatic finish_resp(input int rw, input bit cfg64, input logic [31:0] exp);
        repeat (rw) begin
            step();
            chkb("hold_valid", cfg64 ? b_rv : a_rv, 1'b1);
            chk("hold_data", cfg64 ? b_data : a_data, exp);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chkb("rv_clear_a", a_rv, 1'b0);
        chkb("rv_clear_b", b_rv, 1'b0);
        chkb("adel_clear", a_adel, 1'b0);
        chkb("ready_back_a", a_ready, 1'b1);
        chkb("ready_back_b", b_ready, 1'b1);
    endtask

    typedef struct {
        bit          cfg64;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [63:0] rd;
        logic [31:0] exp_data;
        bit          exp_adel;
        logic [31:0] exp_bad;
        logic [31:0] exp_maddr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int          lat;
        bit          rs;
        logic [31:0] ma32, ma64;
        logic [31:0] got;
        logic [7:0]  ops [7];

        vecs[0]  = '{1'b0, LB,  32'h1001, 64'h8899AABB, 32'hFFFFFF99, 1'b0, 32'h0,    32'h1000, 3};
        vecs[1]  = '{1'b0, LBU, 32'h1003, 64'h8899AABB, 32'h000000BB, 1'b0, 32'h0,    32'h1000, 3};
        vecs[2]  = '{1'b0, LH,  32'h1002, 64'h8899AABB, 32'hFFFFAABB, 1'b0, 32'h0,    32'h1000, 3};
        vecs[3]  = '{1'b0, LHU, 32'h1000, 64'h8899AABB, 32'h00008899, 1'b0, 32'h0,    32'h1000, 3};
        vecs[4]  = '{1'b0, LW,  32'h1000, 64'h8899AABB, 32'h8899AABB, 1'b0, 32'h0,    32'h1000, 3};
        vecs[5]  = '{1'b0, LH,  32'h2001, 64'h8899AABB, 32'h00000000, 1'b1, 32'h2001, 32'h0,    1};
        vecs[6]  = '{1'b0, LW,  32'h2002, 64'h8899AABB, 32'h00000000, 1'b1, 32'h2002, 32'h0,    1};
        vecs[7]  = '{1'b0, LB,  32'h2003, 64'h8899AABB, 32'hFFFFFFBB, 1'b0, 32'h0,    32'h2000, 3};
        vecs[8]  = '{1'b1, LB,  32'h3007, 64'h0123456789ABCDEF, 32'h00000001, 1'b0, 32'h0, 32'h3000, 3};
        vecs[9]  = '{1'b1, LW,  32'h3004, 64'h0123456789ABCDEF, 32'h01234567, 1'b0, 32'h0, 32'h3000, 3};
        vecs[10] = '{1'b1, LHU, 32'h3000, 64'h0123456789ABCDEF, 32'h0000CDEF, 1'b0, 32'h0, 32'h3000, 3};

        ops = '{LB, LBU, LH, LHU, LW, 8'h00, 8'hE2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chkb("rst_req", a_req, 1'b0);
        chkb("rst_rv", a_rv, 1'b0);
        chkb("rst_adel", a_adel, 1'b0);
        chkb("rst_stall", a_stall, 1'b0);
        chkb("rst_ready", a_ready, 1'b1);
        chk("rst_data", a_data, 32'h0);
        chk("rst_bad", a_bad, 32'h0);
        rst = 1'b0;
        step();

        // Directed vectors
        foreach (vecs[i]) begin
            run_load(vecs[i].op, vecs[i].addr, vecs[i].rd, 0, 0, lat, rs, ma32, ma64);
            got = vecs[i].cfg64 ? b_data : a_data;
            chk($sformatf("v%0d_data", i), got, vecs[i].exp_data);
            chkb($sformatf("v%0d_adel", i), vecs[i].cfg64 ? b_adel : a_adel, vecs[i].exp_adel);
            chk($sformatf("v%0d_bad", i), vecs[i].cfg64 ? b_bad : a_bad, vecs[i].exp_bad);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chkb($sformatf("v%0d_req", i), rs, !vecs[i].exp_adel);
            if (!vecs[i].exp_adel)
                chk($sformatf("v%0d_maddr", i), vecs[i].cfg64 ? ma64 : ma32, vecs[i].exp_maddr);
            finish_resp(0, vecs[i].cfg64, vecs[i].exp_data);
        end

        // Flush in DATA, data_ok three cycles later, then a clean load
        rdata32 = 32'h8899AABB;
        ld_valid = 1'b1; ld_op = LW; ld_addr = 32'h1000;
        step();
        ld_valid = 1'b0;
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chkb("fd_rv", a_rv, 1'b0);
        chkb("fd_stall", a_stall, 1'b1);
        chkb("fd_ready0", a_ready, 1'b0);
        step();
        chkb("fd_ready1", a_ready, 1'b0);
        step();
        mem_data_ok = 1'b1;
        step();
        mem_data_ok = 1'b0;
        chkb("fd_ready_back", a_ready, 1'b1);
        chkb("fd_no_result", a_rv, 1'b0);
        step();
        chkb("fd_still_idle", a_rv, 1'b0);
        run_load(LW, 32'h1004, 64'h11223344, 0, 0, lat, rs, ma32, ma64);
        chk("fd_next_data", a_data, 32'h11223344);
        chk("fd_next_maddr", ma32, 32'h1004);
        chk("fd_next_lat", lat, 3);
        finish_resp(0, 1'b0, 32'h11223344);

        // Flush in ADDR before addr_ok, then a stray data_ok in IDLE
        ld_valid = 1'b1; ld_op = LH; ld_addr = 32'h1002;
        step();
        ld_valid = 1'b0;
        chkb("fa_req_up", a_req, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chkb("fa_req_drop", a_req, 1'b0);
        chkb("fa_idle", a_ready, 1'b1);
        mem_data_ok = 1'b1;
        step();
        mem_data_ok = 1'b0;
        chkb("fa_stray_rv", a_rv, 1'b0);
        chkb("fa_stray_ready", a_ready, 1'b1);

        // Flush coincident with addr_ok: drain, discard data
        ld_valid = 1'b1; ld_op = LW; ld_addr = 32'h1000;
        step();
        ld_valid = 1'b0;
        flush = 1'b1; mem_addr_ok = 1'b1;
        step();
        flush = 1'b0; mem_addr_ok = 1'b0;
        chkb("fx_req_drop", a_req, 1'b0);
        chkb("fx_stall", a_stall, 1'b1);
        chkb("fx_ready", a_ready, 1'b0);
        step();
        chkb("fx_stall2", a_stall, 1'b1);
        mem_data_ok = 1'b1;
        step();
        mem_data_ok = 1'b0;
        chkb("fx_ready_back", a_ready, 1'b1);
        chkb("fx_no_result", a_rv, 1'b0);

        // Flush coincident with data_ok: no result
        ld_valid = 1'b1; ld_op = LW; ld_addr = 32'h1000;
        step();
        ld_valid = 1'b0;
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        flush = 1'b1; mem_data_ok = 1'b1;
        step();
        flush = 1'b0; mem_data_ok = 1'b0;
        chkb("fdo_rv", a_rv, 1'b0);
        chkb("fdo_ready", a_ready, 1'b1);

        // Flush in RESP drops a fault result
        run_load(LW, 32'h2002, 64'h0, 0, 0, lat, rs, ma32, ma64);
        chkb("fr_adel", a_adel, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chkb("fr_rv", a_rv, 1'b0);
        chkb("fr_adel_clr", a_adel, 1'b0);
        chk("fr_bad_clr", a_bad, 32'h0);
        chkb("fr_ready", a_ready, 1'b1);

        // Backpressure, and no accept in the cycle that leaves RESP
        run_load(LH, 32'h1002, 64'h8899AABB, 0, 0, lat, rs, ma32, ma64);
        chk("bp_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chkb("bp_valid", a_rv, 1'b1);
            chk("bp_data", a_data, 32'hFFFFAABB);
            chkb("bp_stall", a_stall, 1'b1);
            chkb("bp_ldready", a_ready, 1'b0);
            step();
        end
        chkb("bp_valid_end", a_rv, 1'b1);
        rdata32 = 32'h55667788;
        res_ready = 1'b1;
        ld_valid = 1'b1; ld_op = LW; ld_addr = 32'h1004;
        step();
        res_ready = 1'b0;
        chkb("bp_no_accept", a_req, 1'b0);
        chkb("bp_ready_back", a_ready, 1'b1);
        step();
        ld_valid = 1'b0;
        chkb("bp_accept_next", a_req, 1'b1);
        chk("bp_maddr", a_maddr, 32'h1004);
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        step();
        mem_data_ok = 1'b0;
        chkb("bp_new_rv", a_rv, 1'b1);
        chk("bp_new_data", a_data, 32'h55667788);
        finish_resp(0, 1'b0, 32'h55667788);

        // Randomized loads against the model on both configurations
        for (int n = 0; n < 150; n++) begin
            logic [7:0]  op;
            logic [31:0] addr;
            logic [63:0] rd;
            int          aw, dwt, rw;
            bit          adel;
            logic [31:0] e32, e64;
            op   = ops[$urandom_range(6, 0)];
            addr = $urandom;
            rd   = {$urandom, $urandom};
            aw   = $urandom_range(3, 0);
            dwt  = $urandom_range(3, 0);
            rw   = $urandom_range(2, 0);
            adel = ref_adel(op, addr);
            e32  = ref_val(op, addr, {32'h0, rd[31:0]}, 4, 1'b1);
            e64  = ref_val(op, addr, rd, 8, 1'b0);
            run_load(op, addr, rd, aw, dwt, lat, rs, ma32, ma64);
            chk("rnd_data32", a_data, e32);
            chk("rnd_data64", b_data, e64);
            chkb("rnd_rv64", b_rv, 1'b1);
            chkb("rnd_adel32", a_adel, adel);
            chkb("rnd_adel64", b_adel, adel);
            chk("rnd_bad32", a_bad, adel ? addr : 32'h0);
            chk("rnd_bad64", b_bad, adel ? addr : 32'h0);
            chkb("rnd_stall", b_stall, 1'b1);
            chkb("rnd_req", rs, !adel);
            chk("rnd_lat", lat, adel ? 1 : 3 + aw + dwt);
            if (!adel) begin
                chk("rnd_maddr32", ma32, addr & 32'hFFFF_FFFC);
                chk("rnd_maddr64", ma64, addr & 32'hFFFF_FFF8);
            end
            finish_resp(rw, 1'b0, e32);
        end

        // Reset during DATA aborts immediately
        ld_valid = 1'b1; ld_op = LW; ld_addr = 32'h1008;
        step();
        ld_valid = 1'b0;
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        chkb("rd_stall_pre", a_stall, 1'b1);
        rst = 1'b1;
        #1;
        chkb("rd_req", a_req, 1'b0);
        chkb("rd_rv", a_rv, 1'b0);
        chkb("rd_adel", a_adel, 1'b0);
        chkb("rd_stall", a_stall, 1'b0);
        chkb("rd_ready", a_ready, 1'b1);
        chk("rd_data", a_data, 32'h0);
        chk("rd_bad", a_bad, 32'h0);
        chk("rd_maddr", a_maddr, 32'h0);
        step();
        rst = 1'b0;
        step();
        chkb("rd_idle_after", a_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
